// File: rtl/stepper_pkg.sv
// Shared types and constants for the unipolar stepper phase sequencer.
// The phase table is ordered so that index +1 is a half step and +2 is a full step.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [2:0] IDX_STEP_HALF = 3'd1;
  localparam logic [2:0] IDX_STEP_FULL = 3'd2;

  // Coil pattern {A,B,C,D}; element 0 is the leftmost entry.
  localparam logic [0:7][3:0] PHASE_TABLE = {
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  function automatic logic [3:0] phase_coils(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

  // 3-bit arithmetic gives the modulo-8 wrap in both directions.
  function automatic logic [2:0] next_index(input logic [2:0] idx,
                                            input logic       fwd,
                                            input logic       half);
    logic [2:0] inc;
    inc = half ? IDX_STEP_HALF : IDX_STEP_FULL;
    return fwd ? (idx + inc) : (idx - inc);
  endfunction

endpackage

// File: rtl/lowclock_edge_sync.sv
// Brings the divider's step-rate signal into the system clock domain and
// emits a one-cycle tick per rising edge. SYNC_STAGES must be at least 2.
module lowclock_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Turns step-rate ticks into coil drive for a unipolar stepper, running a
// commanded number of full or half steps under a start/busy/done handshake.
module stepper_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HighClock,
  input  logic              Reset,
  input  logic              LowClock,
  input  logic              Start,
  input  logic              Direction,
  input  logic              HalfStep,
  input  logic [STEP_W-1:0] StepCount,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic [3:0]        Coils,
  output logic [STEP_W-1:0] StepsRemaining
);

  localparam logic [STEP_W-1:0] STEPS_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEPS_ZERO = {STEP_W{1'b0}};

  state_e            state_q, state_d;
  logic              tick_s;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic [2:0]        index_q, index_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [3:0]        coils_q, coils_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  lowclock_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (HighClock),
    .rst_i  (Reset),
    .async_i(LowClock),
    .tick_o (tick_s)
  );

  always_ff @(posedge HighClock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = (StepCount == STEPS_ZERO) ? ST_FINISH : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Abort wins over a coincident tick.
      ST_RUN: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (tick_s && (steps_q == STEPS_ONE)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    half_d    = half_q;
    index_d   = index_q;
    steps_d   = steps_q;
    coils_d   = coils_q;
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_FINISH);
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          dir_d   = Direction;
          half_d  = HalfStep;
          steps_d = StepCount;
          coils_d = phase_coils(index_q);
        end else begin
          coils_d = coils_q;
        end
      end
      ST_RUN: begin
        if (Abort) begin
          aborted_d = 1'b1;
        end else if (tick_s) begin
          index_d = next_index(index_q, dir_q, half_q);
          coils_d = phase_coils(next_index(index_q, dir_q, half_q));
          steps_d = steps_q - STEPS_ONE;
        end else begin
          steps_d = steps_q;
        end
      end
      ST_FINISH: coils_d = coils_q;
      default:   coils_d = coils_q;
    endcase
  end

  always_ff @(posedge HighClock or posedge Reset) begin
    if (Reset) begin
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      index_q   <= 3'd0;
      steps_q   <= STEPS_ZERO;
      coils_q   <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      half_q    <= half_d;
      index_q   <= index_d;
      steps_q   <= steps_d;
      coils_q   <= coils_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Aborted        = aborted_q;
  assign Coils          = coils_q;
  assign StepsRemaining = steps_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Self-checking bench: directed run table plus randomized traffic, compared
// every cycle against a behavioural model of the sequencer.
module tb_stepper_phase_sequencer;

  logic        HighClock = 1'b0;
  logic        Reset     = 1'b1;
  logic        LowClock  = 1'b0;
  logic        Start     = 1'b0;
  logic        Direction = 1'b0;
  logic        HalfStep  = 1'b0;
  logic [15:0] StepCount = 16'd0;
  logic        Abort     = 1'b0;
  logic        Busy, Done, Aborted;
  logic [3:0]  Coils;
  logic [15:0] StepsRemaining;

  stepper_phase_sequencer #(.STEP_W(16), .SYNC_STAGES(2)) dut (
    .HighClock(HighClock), .Reset(Reset), .LowClock(LowClock),
    .Start(Start), .Direction(Direction), .HalfStep(HalfStep),
    .StepCount(StepCount), .Abort(Abort), .Busy(Busy), .Done(Done),
    .Aborted(Aborted), .Coils(Coils), .StepsRemaining(StepsRemaining)
  );

  always #5 HighClock = ~HighClock;

  typedef struct {
    bit         dir;
    bit         half;
    int         count;
    int         abort_tick;  // 0 = never abort
    bit         lc_high;     // accept while LowClock is already high
    bit         restart;     // re-pulse Start after the first tick
    logic [3:0] exp_coils;
    int         exp_rem;
    int         exp_done;
    int         exp_ab;
  } rec_t;

  rec_t       recs[6];
  logic [3:0] tbl[8];

  int n_vec = 0;
  int n_err = 0;

  // model: mode 0 idle, 1 running, 2 finishing
  int         m_mode, m_idx, m_rem;
  bit         m_dir, m_half, m_done, m_ab;
  logic [3:0] m_coils;
  bit         s1, s2, s3;      // LowClock as sampled 1, 2 and 3 edges ago
  int         lc_cnt = 0;
  bit         lc_rand = 1'b0;
  int         done_seen, ab_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_rem = 0; m_coils = 4'b0000;
    m_done = 1'b0; m_ab = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = s2 & ~s3;
    m_done = 1'b0;
    m_ab   = 1'b0;
    if (m_mode == 0) begin
      if (Start) begin
        m_dir = Direction; m_half = HalfStep; m_rem = int'(StepCount);
        m_coils = tbl[m_idx];
        m_mode = (StepCount == 16'd0) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (Abort) begin
        m_mode = 0; m_ab = 1'b1;
      end else if (tk) begin
        m_idx = (m_idx + (m_dir ? 1 : -1) * (m_half ? 1 : 2) + 8) % 8;
        m_coils = tbl[m_idx];
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = 2;
      end
    end else begin
      m_mode = 0;
    end
    m_done = (m_mode == 2);
    s3 = s2; s2 = s1; s1 = LowClock;
  endtask

  task automatic step();
    @(posedge HighClock);
    if (Reset) model_reset();
    else model_edge();
    #1;
    check("cycle {busy,done,aborted,coils,remaining}",
          {11'd0, Busy, Done, Aborted, Coils, StepsRemaining},
          {11'd0, m_mode == 1, m_done, m_ab, m_coils, m_rem[15:0]});
    if (Done) done_seen++;
    if (Aborted) ab_seen++;
    if (lc_rand) begin
      if ($urandom_range(0, 3) == 0) LowClock = ~LowClock;
    end else begin
      lc_cnt++;
      if (lc_cnt >= 10) begin
        lc_cnt = 0;
        LowClock = ~LowClock;
      end
    end
  endtask

  initial begin
    rec_t r;
    int   ticks, guard, w;
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    recs[0] = '{1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 4'b0010, 0, 1, 0};
    recs[1] = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 4'b1100, 0, 1, 0};
    recs[2] = '{1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 4'b0110, 0, 1, 0};
    recs[3] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 4'b0110, 0, 1, 0};
    recs[4] = '{1'b1, 1'b1, 5, 2, 1'b0, 1'b0, 4'b0010, 4, 0, 1};
    recs[5] = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 4'b1000, 0, 1, 0};
    model_reset();

    #2;
    check("reset outputs", {Busy, Done, Aborted, Coils, StepsRemaining}, 23'd0);
    repeat (3) step();
    Reset = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 6; i++) begin
      r = recs[i];
      done_seen = 0; ab_seen = 0; ticks = 0;
      if (r.lc_high) begin
        w = 0;
        while (LowClock !== 1'b1 && w < 100) begin step(); w++; end
      end
      Direction = r.dir; HalfStep = r.half; StepCount = r.count[15:0];
      Start = 1'b1;
      step();
      Start = 1'b0; Direction = ~r.dir; HalfStep = ~r.half; StepCount = 16'hFFFF;
      guard = 0;
      while (m_mode != 0 && guard < 1000) begin
        Abort = 1'b0; Start = 1'b0;
        if (m_mode == 1 && s2 && !s3) begin
          ticks++;
          if (ticks == r.abort_tick) Abort = 1'b1;
          if (r.restart && ticks == 1) Start = 1'b1;
        end
        step();
        guard++;
      end
      Abort = 1'b0; Start = 1'b0;
      if (guard >= 1000) begin
        n_vec++; n_err++;
        $display("FAIL run %0d timeout: model still busy after %0d cycles", i, guard);
      end
      repeat (5) step();
      check($sformatf("run %0d coils", i), {28'd0, Coils}, {28'd0, r.exp_coils});
      check($sformatf("run %0d remaining", i), {16'd0, StepsRemaining}, r.exp_rem);
      check($sformatf("run %0d done pulses", i), done_seen, r.exp_done);
      check($sformatf("run %0d aborted pulses", i), ab_seen, r.exp_ab);
    end

    // asynchronous reset in the middle of a run
    Direction = 1'b1; HalfStep = 1'b1; StepCount = 16'd5; Start = 1'b1;
    step();
    Start = 1'b0;
    w = 0;
    while (m_rem == 5 && w < 100) begin step(); w++; end
    step();
    #2 Reset = 1'b1;
    #1;
    check("async reset coils/busy", {Coils, Busy, Done}, 6'd0);
    model_reset();
    done_seen = 0;
    repeat (3) step();
    Reset = 1'b0;
    repeat (30) step();
    check("no done after reset", done_seen, 0);

    // randomized traffic
    lc_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      Start     = ($urandom_range(0, 19) == 0);
      Direction = $urandom_range(0, 1);
      HalfStep  = $urandom_range(0, 1);
      StepCount = 16'($urandom_range(0, 6));
      Abort     = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
